// File: rtl/pb_debounce_onepulse.sv
// pb_debounce_onepulse
// Receive side of the stopwatch push buttons (pbsec, pbmin, pbpause, pbstart).
// Each raw button goes through a 2-FF synchronizer and is debounced on the 100 Hz
// sample strobe. The block then emits a one-clock press pulse and an auto-repeat
// pulse train that is used for fast sec/min setting while a button is held.
// Reset asserts asynchronously. Its release is re-timed by a local 2-FF chain, so
// every flop leaves reset on the same clock edge.

module pb_debounce_onepulse #(
  parameter int NUM_PB       = 4,
  parameter int DEB_LEN      = 4,
  parameter int HOLD_TICKS   = 50,
  parameter int REPEAT_TICKS = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sample_en,
  input  logic [NUM_PB-1:0] pb_in,
  output logic [NUM_PB-1:0] pb_level,
  output logic [NUM_PB-1:0] pb_pulse,
  output logic [NUM_PB-1:0] pb_repeat,
  output logic              pb_any
);

  // The tick counter must hold the larger of the two intervals. It is cleared
  // at its terminal value, so it never wraps.
  localparam int CNT_MAX = (HOLD_TICKS > REPEAT_TICKS) ? HOLD_TICKS : REPEAT_TICKS;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;

  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_TICKS - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_TICKS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PRESS  = 2'd1,
    ST_REPEAT = 2'd2
  } pb_state_e;

  logic [1:0]        rst_sync;
  logic              rst_ok;
  logic [NUM_PB-1:0] sync_meta;
  logic [NUM_PB-1:0] sync_q;

  // Release of reset is delayed two clocks so the whole block leaves reset together
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync <= 2'b00;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
    end
  end

  assign rst_ok = rst_sync[1];

  // Two-stage synchronizer bringing the asynchronous buttons into the clk domain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_meta <= '0;
      sync_q    <= '0;
    end else if (!rst_ok) begin
      sync_meta <= '0;
      sync_q    <= '0;
    end else begin
      sync_meta <= pb_in;
      sync_q    <= sync_meta;
    end
  end

  for (genvar i = 0; i < NUM_PB; i++) begin : gen_pb

    logic [DEB_LEN-1:0] shift_q;
    logic [DEB_LEN-1:0] shift_next;
    logic               level_q;
    logic               level_d_q;
    logic               pulse_q;
    logic               rise;
    pb_state_e          state_q;
    pb_state_e          state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic               rep_q;
    logic               rep_d;

    // The level decision looks at the shift register as it will be after this
    // sample. A change of level therefore needs DEB_LEN equal samples in a row.
    assign shift_next = {shift_q[DEB_LEN-2:0], sync_q[i]};
    assign rise       = level_q & ~level_d_q;

    // Debounce shift register and debounced level, both advanced only on sample ticks
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        shift_q <= '0;
        level_q <= 1'b0;
      end else if (!rst_ok) begin
        shift_q <= '0;
        level_q <= 1'b0;
      end else if (sample_en) begin
        shift_q <= shift_next;
        if (&shift_next) begin
          level_q <= 1'b1;
        end else if (~|shift_next) begin
          level_q <= 1'b0;
        end
      end
    end

    // Rising-edge detector for the press pulse; not gated by sample_en, so a pending pulse always completes
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        level_d_q <= 1'b0;
        pulse_q   <= 1'b0;
      end else if (!rst_ok) begin
        level_d_q <= 1'b0;
        pulse_q   <= 1'b0;
      end else begin
        level_d_q <= level_q;
        pulse_q   <= rise;
      end
    end

    // Auto-repeat FSM state register, tick counter and registered repeat pulse
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q <= ST_IDLE;
        cnt_q   <= '0;
        rep_q   <= 1'b0;
      end else if (!rst_ok) begin
        state_q <= ST_IDLE;
        cnt_q   <= '0;
        rep_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        rep_q   <= rep_d;
      end
    end

    // Next state: the press is taken on the level edge; holding and repeating advance on sample ticks
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rep_d   = 1'b0;
      if (!level_q) begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (rise) begin
              state_d = ST_PRESS;
              cnt_d   = '0;
              rep_d   = 1'b1;
            end
          end
          ST_PRESS: begin
            if (sample_en) begin
              if (cnt_q == HOLD_LAST) begin
                state_d = ST_REPEAT;
                cnt_d   = '0;
                rep_d   = 1'b1;
              end else begin
                cnt_d = cnt_q + CNT_ONE;
              end
            end
          end
          ST_REPEAT: begin
            if (sample_en) begin
              if (cnt_q == REPEAT_LAST) begin
                cnt_d = '0;
                rep_d = 1'b1;
              end else begin
                cnt_d = cnt_q + CNT_ONE;
              end
            end
          end
          default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end
        endcase
      end
    end

    assign pb_level[i]  = level_q;
    assign pb_pulse[i]  = pulse_q;
    assign pb_repeat[i] = rep_q;

  end : gen_pb

  assign pb_any = |pb_level;

endmodule
